// File: rtl/mem_scroll_reader_pkg.sv
// Shared types and constants for the scrolling seven-segment memory reader.
package mem_scroll_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int NUM_SLOTS = 6;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Active-low DE1 patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [3:0] next_addr(input logic [3:0] a, input logic [4:0] len);
    return ({1'b0, a} == len - 5'd1) ? 4'd0 : a + 4'd1;
  endfunction

  function automatic logic [4:0] sat_len(input logic [4:0] l);
    return (l > 5'd16) ? 5'd16 : l;
  endfunction

endpackage

// File: rtl/mem_scroll_reader_if.sv
// Read port between the scroll reader and the digit memory (synchronous, one-cycle latency).
interface mem_scroll_reader_if;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/mem_scroll_reader_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import mem_scroll_reader_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = BLANK_SEG;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/mem_scroll_reader.sv
// Scrolls a window of six digits from the digit memory across HEX5..HEX0.
// state | meaning: IDLE = stopped, display frozen | FETCH = reading 6 slots into shadow | SHOW = dwell TICK_DIV cycles
module mem_scroll_reader
  import mem_scroll_reader_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [4:0]                 length,
  mem_scroll_reader_if.master        mem,
  output logic [6:0]                 HEX5,
  output logic [6:0]                 HEX4,
  output logic [6:0]                 HEX3,
  output logic [6:0]                 HEX2,
  output logic [6:0]                 HEX1,
  output logic [6:0]                 HEX0,
  output logic                       busy,
  output logic [3:0]                 base
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

  state_t        state;
  logic          start_d;
  logic [4:0]    len_q;
  logic [3:0]    ptr;
  logic [2:0]    cnt;
  logic [TW-1:0] tick_q;
  logic [3:0]    base_q;
  logic [3:0]    rd_addr_q;

  logic [3:0]    shadow_dig   [NUM_SLOTS-1];
  logic [NUM_SLOTS-2:0] shadow_blank;
  logic [6:0]    hex_q        [NUM_SLOTS];

  logic [3:0]    dig_src      [NUM_SLOTS];
  logic [6:0]    seg          [NUM_SLOTS];
  logic [3:0]    next_base;

  // The last slot is committed on the same edge its data arrives, so it bypasses the shadow.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS - 1; i++) dig_src[i] = shadow_dig[i];
    dig_src[NUM_SLOTS-1] = mem.rd_data;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_dec
    hex7seg u_hex7seg (
      .digit (dig_src[g]),
      .seg   (seg[g])
    );
  end

  assign next_base = next_addr(base_q, len_q);

  // start is registered so a restart always begins from a clean edge with the new length in place
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_d      <= 1'b0;
      len_q        <= 5'd0;
      ptr          <= 4'd0;
      cnt          <= 3'd0;
      tick_q       <= '0;
      base_q       <= 4'd0;
      rd_addr_q    <= 4'd0;
      shadow_blank <= '1;
      for (int i = 0; i < NUM_SLOTS - 1; i++) shadow_dig[i] <= 4'd0;
      for (int i = 0; i < NUM_SLOTS; i++) hex_q[i] <= BLANK_SEG;
    end else begin
      start_d <= start;
      if (start) len_q <= sat_len(length);

      if (start_d) begin
        if (len_q == 5'd0) begin
          for (int i = 0; i < NUM_SLOTS; i++) hex_q[i] <= BLANK_SEG;
          state <= IDLE;
        end else begin
          base_q    <= 4'd0;
          rd_addr_q <= 4'd0;
          ptr       <= next_addr(4'd0, len_q);
          cnt       <= 3'd0;
          state     <= FETCH;
        end
      end else if (start) begin
        // hold everything for the cycle the start is being registered
      end else if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          FETCH: begin
            if (cnt < 3'd5) begin
              rd_addr_q <= ptr;
              ptr       <= next_addr(ptr, len_q);
            end
            if (cnt != 3'd0 && cnt != 3'd6) begin
              shadow_dig[cnt - 3'd1]   <= mem.rd_data;
              shadow_blank[cnt - 3'd1] <= ({2'b00, cnt - 3'd1} >= len_q);
            end
            if (cnt == 3'd6) begin
              for (int i = 0; i < NUM_SLOTS - 1; i++)
                hex_q[i] <= shadow_blank[i] ? BLANK_SEG : seg[i];
              hex_q[NUM_SLOTS-1] <= (len_q <= 5'(NUM_SLOTS - 1)) ? BLANK_SEG : seg[NUM_SLOTS-1];
              tick_q <= TICK_LOAD;
              state  <= SHOW;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          SHOW: begin
            if (tick_q == '0) begin
              base_q    <= next_base;
              rd_addr_q <= next_base;
              ptr       <= next_addr(next_base, len_q);
              cnt       <= 3'd0;
              state     <= FETCH;
            end else begin
              tick_q <= tick_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem.rd_addr = rd_addr_q;
  assign base        = base_q;
  assign busy        = (state != IDLE);
  assign HEX5        = hex_q[0];
  assign HEX4        = hex_q[1];
  assign HEX3        = hex_q[2];
  assign HEX2        = hex_q[3];
  assign HEX1        = hex_q[4];
  assign HEX0        = hex_q[5];

endmodule

// File: doc/mem_scroll_reader.md
MEM_SCROLL_READER -- requirements
Module: mem_scroll_reader

Interface
REQ-001 Parameter TICK_DIV, default 5_000_000, clock cycles per scroll step (0.1 s at 50 MHz); benches override it with a small value.
REQ-002 CLOCK_50  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; latches length and begins scrolling from address 0.
REQ-005 stop  input  1  single-cycle pulse; halts scrolling and freezes the display.
REQ-006 length  input  5  number of valid digits stored in memory, 0..16; values >16 are treated as 16.
REQ-007 rd_addr  output  4  read address to the digit memory written by the digit-entry block.
REQ-008 rd_data  input  4  memory read data; valid exactly one cycle after rd_addr.
REQ-009 HEX5..HEX0  output  7 each  active-low seven-segment patterns; HEX5 is the leftmost slot (slot 0).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 base  output  4  address currently shown on HEX5.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, FETCH and SHOW.
REQ-013 IDLE: on start with latched length 0, SHALL blank all HEX outputs and remain in IDLE; on start with length ≥1, SHALL set base=0 and enter FETCH.
REQ-014 FETCH: SHALL issue 6 reads on consecutive cycles, starting at ptr=base; after each read, ptr = (ptr == len-1) ? 0 : ptr+1.
REQ-015 FETCH: data for slot i SHALL be captured into a shadow buffer one cycle after its address; FETCH therefore lasts exactly 7 cycles.
REQ-016 Slots with index i ≥ len SHALL be loaded as blank (7'h7F), not with memory data.
REQ-017 All six HEX outputs SHALL update together from the shadow buffer on the final FETCH edge, so no partial window is ever displayed; the first window appears 8 rising edges after the edge that samples start.
REQ-018 SHOW: SHALL count TICK_DIV cycles, then set base = (base == len-1) ? 0 : base+1 and return to FETCH.
REQ-019 Decoding SHALL cover the full hex range 0-F with standard active-low DE1 patterns.
REQ-020 length SHALL be latched only on an accepted start; later changes to length SHALL have no effect until the next start.
REQ-021 stop in FETCH or SHOW SHALL return the FSM to IDLE within one cycle, keeping the HEX outputs and base unchanged; an aborted fetch SHALL NOT update the display.
REQ-022 start while busy SHALL restart from base=0 with a newly latched length; if start and stop are asserted together, start SHALL win.
REQ-023 rd_addr SHALL hold its last value outside FETCH.

Reset
REQ-024 On reset: state=IDLE, HEX5..HEX0=7'h7F, rd_addr=0, base=0, busy=0, tick counter=0, latched length=0, shadow buffer blank.
REQ-025 Reset asserted mid-FETCH or mid-SHOW SHALL take effect immediately, with no pending display update surviving.

Structure
REQ-026 A shared package SHALL hold the state enum, the BLANK_SEG constant (7'h7F), the 16 segment pattern constants and NUM_SLOTS=6.
REQ-027 One sub-module, hex7seg (4-bit in, 7-bit active-low out, purely combinational), SHALL be instantiated once per slot.

Verification
REQ-028 Memory 0..6 = 2,4,0,5,2,0,2; length=7; start -> 8 edges later HEX5..HEX0 show 2,4,0,5,2,0; after TICK_DIV they show 4,0,5,2,0,2.
REQ-029 Same memory, run 7 ticks -> base wraps 6→0; the window at base=5 shows 0,2,2,4,0,5.
REQ-030 length=3, memory 7,8,9 -> HEX5..HEX3 = 7,8,9; HEX2..HEX0 blank; after one tick HEX5..HEX3 = 8,9,7.
REQ-031 length=0, start -> all HEX blank; busy stays 0; rd_addr unchanged.
REQ-032 stop 3 cycles into FETCH -> busy falls next cycle; HEX and base unchanged; a later start restarts at base=0.
REQ-033 reset pulse during SHOW -> all outputs return to reset values asynchronously; no display change after reset is released until a new start.
